i2s_audio_tx: RTL

Serializes the 6-bit mixed APU sample (rp2a03 `dac_audio_out`, exported at top level when `USE_DAC_AUDIO` is defined) into a standard Philips I2S stream for an external stereo audio DAC. It sits directly downstream of the rp2a03 in the system clock domain. It generates BCLK and LRCK from the 100 MHz system clock, converts the unsigned sample to 16-bit signed, and drives the same word on both channels.

---
 rtl/i2s_pkg.sv | 21 ++
 rtl/i2s_bclk_gen.sv | 33 +++
 rtl/i2s_audio_tx.sv | 75 +++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and sample conversion for the I2S audio transmitter.
// The APU produces a 6-bit unsigned level; the DAC expects 16-bit signed PCM.
package i2s_pkg;

  localparam int I2S_WORD_BITS  = 16;
  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FRAME_BITS = 64;
  localparam int DAC_AUDIO_BITS = 6;

  localparam int BIT_CNT_W = $clog2(I2S_FRAME_BITS);
  localparam int SLOT_W    = $clog2(I2S_SLOT_BITS);
  localparam int PCM_PAD   = I2S_WORD_BITS - DAC_AUDIO_BITS;

  // Flipping the MSB turns offset-binary (32 = silence) into two's complement.
  function automatic logic [I2S_WORD_BITS-1:0] dac_to_pcm16(
    input logic [DAC_AUDIO_BITS-1:0] s
  );
    return {s ^ {1'b1, {(DAC_AUDIO_BITS-1){1'b0}}}, {PCM_PAD{1'b0}}};
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_HALF system clocks and flags
// the clock in which bclk is about to fall, so framing logic can update with it.
module i2s_bclk_gen #(
  parameter int BCLK_HALF = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic bclk,
  output logic fall
);

  localparam int DIV_W = (BCLK_HALF <= 2) ? 1 : $clog2(BCLK_HALF);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap = (div_cnt == DIV_LAST);
  assign fall = wrap & bclk;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips I2S transmitter for the mixed APU sample: same 16-bit word on both
// channels, one sample taken per 64-bit frame, one-bit delay after LRCK edge.
module i2s_audio_tx
  import i2s_pkg::*;
#(
  parameter int BCLK_HALF = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [DAC_AUDIO_BITS-1:0] dac_audio_in,
  input  logic                      mute_in,
  output logic                      i2s_bclk_out,
  output logic                      i2s_lrck_out,
  output logic                      i2s_sdata_out,
  output logic                      sample_strobe_out
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(I2S_FRAME_BITS - 1);
  localparam logic [SLOT_W-1:0]    MSB_POS  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0]    LSB_POS  = SLOT_W'(I2S_WORD_BITS);

  logic                     bclk;
  logic                     fall;
  logic [BIT_CNT_W-1:0]     bit_cnt;
  logic [BIT_CNT_W-1:0]     bit_nxt;
  logic [SLOT_W-1:0]        slot_pos;
  logic [3:0]               bit_idx;
  logic [I2S_WORD_BITS-1:0] word;
  logic [I2S_WORD_BITS-1:0] word_nxt;
  logic                     latch;
  logic                     sdata_nxt;

  i2s_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bclk   (bclk),
    .fall   (fall)
  );

  assign bit_nxt  = bit_cnt + 1'b1;
  assign slot_pos = bit_nxt[SLOT_W-1:0];
  assign bit_idx  = 4'(LSB_POS - slot_pos);
  assign latch    = fall && (bit_cnt == LAST_BIT);
  assign word_nxt = mute_in ? '0 : dac_to_pcm16(dac_audio_in);

  // Data is selected for the position being entered, so it leads the
  // following bclk rise by a full half period.
  always_comb begin
    sdata_nxt = 1'b0;
    if (slot_pos >= MSB_POS && slot_pos <= LSB_POS)
      sdata_nxt = word[bit_idx];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bit_cnt           <= '0;
      word              <= '0;
      i2s_lrck_out      <= 1'b0;
      i2s_sdata_out     <= 1'b0;
      sample_strobe_out <= 1'b0;
    end else begin
      sample_strobe_out <= latch;
      if (fall) begin
        bit_cnt       <= bit_nxt;
        i2s_lrck_out  <= bit_nxt[BIT_CNT_W-1];
        i2s_sdata_out <= sdata_nxt;
        if (latch)
          word <= word_nxt;
      end
    end
  end

  assign i2s_bclk_out = bclk;

endmodule
